audio_pwm_player: RTL and testbench

//  Parametrised PCM-to-PWM audio player. Successor to the fixed song PWM generator.
//  - Fetches packed unsigned samples from a synchronous sample ROM, 1-cycle read latency.
//  - Paces them at a programmable sample rate, with address range, loop, pause and volume.
//  - Drives a glitch-free PWM pin and the amplifier shutdown pin.

---
 rtl/audio_pwm_player.sv | 251 +++++++++++++++++++++++++
 tb/tb_audio_pwm_player.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_player.sv
// -----------------------------------------------------------------------------
// audio_pwm_player
//   PCM-to-PWM audio player. Reads packed unsigned samples from a synchronous
//   ROM (one-cycle read latency), paces them at SAMPLE_HZ, applies a volume
//   shift and plays them as glitch-free PWM. Supports an address range,
//   looping, pause/resume and stop.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   cmd_play_i     pulse: (re)start playback at start_addr_i
//   cmd_stop_i     pulse: stop and go idle
//   cmd_pause_i    pulse: toggle PLAY <-> PAUSE
//   loop_i         level: wrap to the start address after the end address
//   vol_i          attenuation, sample >> vol_i
//   start_addr_i   first ROM word (inclusive), captured on an accepted play
//   end_addr_i     last ROM word (inclusive), captured on an accepted play
//   mem_rd_en_o    ROM read strobe
//   mem_addr_o     ROM address
//   mem_data_i     ROM data, valid the cycle after mem_rd_en_o
//   pwm_out_o      PWM audio output
//   aud_sd_o       amplifier enable (0 = shutdown)
//   busy_o         high in PLAY or PAUSE
//   done_o         one-cycle pulse when a non-looping range finishes
// -----------------------------------------------------------------------------
module audio_pwm_player #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SAMPLE_HZ = 48_000,
  parameter int SAMPLE_W  = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_play_i,
  input  logic              cmd_stop_i,
  input  logic              cmd_pause_i,
  input  logic              loop_i,
  input  logic [2:0]        vol_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              pwm_out_o,
  output logic              aud_sd_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int SPW   = DATA_W / SAMPLE_W;
  localparam int SUB_W = (SPW > 1) ? $clog2(SPW) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SAMPLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] duty_q, duty_d;
  logic [SAMPLE_W-1:0] pend_q, pend_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_pend_q, rd_pend_d;
  logic                last_q, last_d;
  logic                pwm_q, pwm_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                play_ok_s;

  // Selects sample idx of a packed word, LSB-first.
  function automatic logic [SAMPLE_W-1:0] pick_sample(input logic [DATA_W-1:0] word,
                                                      input logic [SUB_W-1:0]  idx);
    logic [SAMPLE_W-1:0] res;
    res = word[SAMPLE_W-1:0];
    for (int i = 0; i < SPW; i++) begin
      if (idx == SUB_W'(i)) begin
        res = word[i*SAMPLE_W +: SAMPLE_W];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state logic: sample pacing, word fetch, PWM and command handling.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    duty_d       = duty_q;
    pend_d       = pend_q;
    sub_d        = sub_q;
    addr_d       = addr_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    last_d       = last_q;
    rd_en_d      = 1'b0;
    rd_pend_d    = rd_en_q;
    play_ok_s    = cmd_play_i && (start_addr_i <= end_addr_i) && (state_q != S_DONE);

    // ROM data lands one cycle after the strobe.
    if (rd_pend_q) begin
      word_d = mem_data_i;
    end else begin
      word_d = word_q;
    end

    case (state_q)
      S_PLAY: begin
        cnt_d = cnt_q + SAMPLE_W'(1);
        // Duty only reloads at the start of a PWM period so a pulse is never cut.
        if (cnt_q == '0) begin
          duty_d = pend_q;
        end else begin
          duty_d = duty_q;
        end
        if (div_q == DIV_W'(DIV - 1)) begin
          div_d = '0;
          // The tick after the final word is exhausted ends playback.
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            pend_d = pick_sample(word_q, sub_q) >> vol_i;
            if (sub_q == SUB_W'(SPW - 1)) begin
              sub_d = '0;
              if (addr_q != end_addr_q) begin
                addr_d  = addr_q + ADDR_W'(1);
                rd_en_d = 1'b1;
              end else if (loop_i) begin
                addr_d  = start_addr_q;
                rd_en_d = 1'b1;
              end else begin
                last_d = 1'b1;
              end
            end else begin
              sub_d = sub_q + SUB_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_IDLE, S_PAUSE: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Commands: stop beats play, play beats pause.
    if (cmd_stop_i) begin
      state_d = S_IDLE;
    end else if (play_ok_s) begin
      state_d      = S_PLAY;
      addr_d       = start_addr_i;
      start_addr_d = start_addr_i;
      end_addr_d   = end_addr_i;
      rd_en_d      = 1'b1;
      div_d        = '0;
      sub_d        = '0;
      last_d       = 1'b0;
    end else if (cmd_pause_i && (state_q == S_PLAY) && (state_d == S_PLAY)) begin
      state_d = S_PAUSE;
    end else if (cmd_pause_i && (state_q == S_PAUSE)) begin
      state_d = S_PLAY;
    end else begin
      state_d = state_d;
    end

    // Leaving playback silences the output and drops any in-flight fetch.
    if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
      cnt_d     = '0;
      duty_d    = '0;
      pend_d    = '0;
      div_d     = '0;
      sub_d     = '0;
      last_d    = 1'b0;
      rd_en_d   = 1'b0;
      rd_pend_d = 1'b0;
    end else begin
      last_d = last_d;
    end

    // Outputs are computed from next-state values so the registers track the state.
    pwm_d    = (state_d == S_PLAY) && (cnt_d < duty_d);
    active_d = (state_d == S_PLAY) || (state_d == S_PAUSE);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      duty_q       <= '0;
      pend_q       <= '0;
      sub_q        <= '0;
      addr_q       <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      word_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      last_q       <= 1'b0;
      pwm_q        <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      duty_q       <= duty_d;
      pend_q       <= pend_d;
      sub_q        <= sub_d;
      addr_q       <= addr_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      word_q       <= word_d;
      rd_en_q      <= rd_en_d;
      rd_pend_q    <= rd_pend_d;
      last_q       <= last_d;
      pwm_q        <= pwm_d;
      active_q     <= active_d;
      done_q       <= done_d;
    end
  end

  assign mem_rd_en_o = rd_en_q;
  assign mem_addr_o  = addr_q;
  assign pwm_out_o   = pwm_q;
  assign aud_sd_o    = active_q;
  assign busy_o      = active_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_audio_pwm_player.sv
// -----------------------------------------------------------------------------
// tb_audio_pwm_player
//   Directed bench for audio_pwm_player with DIV=10, SAMPLE_W=4, DATA_W=8
//   (two samples per word), ADDR_W=4. A table of {setup, cycle offset,
//   expected outputs} records is replayed from reset, followed by hand-written
//   sequences for pause/resume, stop, restart, reset and looping.
//   Offset k counts cycles from the first PLAY cycle (k=0).
// -----------------------------------------------------------------------------
module tb_audio_pwm_player;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_play, cmd_stop, cmd_pause, loop_en;
  logic [2:0] vol;
  logic [3:0] start_addr, end_addr;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       pwm_out, aud_sd, busy, done;

  logic [7:0] rom [16];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] sa;
    logic [3:0] ea;
    logic       lp;
    logic [2:0] v;
    int         k;
    logic       rd;
    logic [3:0] a;
    logic [3:0] p;
    logic       pw;
    logic       sd;
    logic       dn;
  } vec_t;

  vec_t vt[$];

  audio_pwm_player #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .SAMPLE_W(4), .DATA_W(8), .ADDR_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_play_i(cmd_play), .cmd_stop_i(cmd_stop), .cmd_pause_i(cmd_pause),
    .loop_i(loop_en), .vol_i(vol),
    .start_addr_i(start_addr), .end_addr_i(end_addr),
    .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .pwm_out_o(pwm_out), .aud_sd_o(aud_sd), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) mem_data <= 8'h00;
    else if (mem_rd_en) mem_data <= rom[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_play = 1'b0; cmd_stop = 1'b0; cmd_pause = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  // Returns at k=0 (first PLAY cycle) when the command is accepted.
  task automatic start_play(input logic [3:0] s, input logic [3:0] e, input logic l, input logic [2:0] v);
    start_addr = s; end_addr = e; loop_en = l; vol = v;
    cmd_play = 1'b1;
    step(1);
    cmd_play = 1'b0;
  endtask

  function automatic void add(input logic [3:0] sa, input logic [3:0] ea, input logic lp,
                              input logic [2:0] v, input int k, input logic rd, input logic [3:0] a,
                              input logic [3:0] p, input logic pw, input logic sd, input logic dn);
    vec_t r;
    r.sa = sa; r.ea = ea; r.lp = lp; r.v = v; r.k = k;
    r.rd = rd; r.a = a; r.p = p; r.pw = pw; r.sd = sd; r.dn = dn;
    vt.push_back(r);
  endfunction

  initial begin
    int hi;
    int cnt_bad;
    rst = 1'b1; cmd_play = 1'b0; cmd_stop = 1'b0; cmd_pause = 1'b0;
    loop_en = 1'b0; vol = 3'd0; start_addr = 4'd0; end_addr = 4'd0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[2] = 8'h3C; rom[3] = 8'hF1; rom[5] = 8'hCC;

    //    sa     ea     lp    v     k   rd    addr   pend   pwm   sd    done
    // range 2..3, no loop: samples C,3,1,F, done at k=50
    add(4'd2, 4'd3, 1'b0, 3'd0,  0, 1'b1, 4'd2, 4'h0, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0,  1, 1'b0, 4'd2, 4'h0, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0,  9, 1'b0, 4'd2, 4'h0, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 10, 1'b0, 4'd2, 4'hC, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 16, 1'b0, 4'd2, 4'hC, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 17, 1'b0, 4'd2, 4'hC, 1'b1, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 20, 1'b1, 4'd3, 4'h3, 1'b1, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 28, 1'b0, 4'd3, 4'h3, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 30, 1'b0, 4'd3, 4'h1, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 33, 1'b0, 4'd3, 4'h1, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 40, 1'b0, 4'd3, 4'hF, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 49, 1'b0, 4'd3, 4'hF, 1'b1, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd0, 50, 1'b0, 4'd3, 4'h0, 1'b0, 1'b0, 1'b1);
    add(4'd2, 4'd3, 1'b0, 3'd0, 51, 1'b0, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    // looping: after word 3 the next read is word 2
    add(4'd2, 4'd3, 1'b1, 3'd0, 40, 1'b1, 4'd2, 4'hF, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b1, 3'd0, 50, 1'b0, 4'd2, 4'hC, 1'b1, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b1, 3'd0, 60, 1'b1, 4'd3, 4'h3, 1'b1, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b1, 3'd1, 40, 1'b1, 4'd2, 4'h7, 1'b0, 1'b1, 1'b0);
    // volume shift by 2
    add(4'd2, 4'd3, 1'b0, 3'd2, 10, 1'b0, 4'd2, 4'h3, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd2, 17, 1'b0, 4'd2, 4'h3, 1'b1, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd2, 19, 1'b0, 4'd2, 4'h3, 1'b0, 1'b1, 1'b0);
    add(4'd2, 4'd3, 1'b0, 3'd2, 20, 1'b1, 4'd3, 4'h0, 1'b0, 1'b1, 1'b0);
    // start > end is ignored
    add(4'd5, 4'd4, 1'b0, 3'd0,  0, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(4'd5, 4'd4, 1'b0, 3'd0,  3, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    // single-word range
    add(4'd5, 4'd5, 1'b0, 3'd0, 20, 1'b0, 4'd5, 4'hC, 1'b1, 1'b1, 1'b0);
    add(4'd5, 4'd5, 1'b0, 3'd0, 30, 1'b0, 4'd5, 4'h0, 1'b0, 1'b0, 1'b1);
    add(4'd5, 4'd5, 1'b1, 3'd0, 20, 1'b1, 4'd5, 4'hC, 1'b1, 1'b1, 1'b0);

    // reset state
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst.rd", mem_rd_en, 1'b0);
    chk("rst.addr", mem_addr, 4'd0);
    chk("rst.pwm", pwm_out, 1'b0);
    chk("rst.sd", aud_sd, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);

    // table-driven vectors, each replayed from reset
    foreach (vt[i]) begin
      do_reset();
      start_play(vt[i].sa, vt[i].ea, vt[i].lp, vt[i].v);
      step(vt[i].k);
      chk($sformatf("v%0d.rd", i), mem_rd_en, vt[i].rd);
      chk($sformatf("v%0d.addr", i), mem_addr, vt[i].a);
      chk($sformatf("v%0d.pend", i), dut.pend_q, vt[i].p);
      chk($sformatf("v%0d.pwm", i), pwm_out, vt[i].pw);
      chk($sformatf("v%0d.sd", i), aud_sd, vt[i].sd);
      chk($sformatf("v%0d.busy", i), busy, vt[i].sd);
      chk($sformatf("v%0d.done", i), done, vt[i].dn);
    end

    // PWM high time over one full period with a constant sample C
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      start_play(4'd5, 4'd5, 1'b1, (pass == 0) ? 3'd0 : 3'd2);
      step(32);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
        hi += int'(pwm_out);
        step(1);
      end
      chk($sformatf("pwm.high.vol%0d", pass * 2), hi, (pass == 0) ? 12 : 3);
    end

    // pause at k=21, hold, resume with the divider where it stopped
    do_reset();
    start_play(4'd2, 4'd3, 1'b0, 3'd0);
    step(21);
    chk("pause.pre_pwm", pwm_out, 1'b1);
    cmd_pause = 1'b1;
    step(1);
    cmd_pause = 1'b0;
    chk("pause.pwm", pwm_out, 1'b0);
    chk("pause.sd", aud_sd, 1'b1);
    chk("pause.busy", busy, 1'b1);
    cnt_bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (mem_rd_en !== 1'b0 || pwm_out !== 1'b0 || aud_sd !== 1'b1) cnt_bad++;
    end
    chk("pause.hold", cnt_bad, 0);
    cmd_pause = 1'b1;
    step(1);
    cmd_pause = 1'b0;
    chk("resume.pwm", pwm_out, 1'b1);
    step(7);
    chk("resume.pend_before", dut.pend_q, 4'h3);
    step(1);
    chk("resume.pend_tick", dut.pend_q, 4'h1);

    // cmd_play while paused restarts
    do_reset();
    start_play(4'd2, 4'd3, 1'b0, 3'd0);
    step(3);
    cmd_pause = 1'b1;
    step(1);
    cmd_pause = 1'b0;
    start_addr = 4'd5; end_addr = 4'd5;
    cmd_play = 1'b1;
    step(1);
    cmd_play = 1'b0;
    chk("pplay.rd", mem_rd_en, 1'b1);
    chk("pplay.addr", mem_addr, 4'd5);

    // stop and play together: stop wins
    do_reset();
    start_play(4'd2, 4'd3, 1'b0, 3'd0);
    step(20);
    cmd_stop = 1'b1; cmd_play = 1'b1;
    step(1);
    cmd_stop = 1'b0; cmd_play = 1'b0;
    chk("stopplay.busy", busy, 1'b0);
    chk("stopplay.sd", aud_sd, 1'b0);
    chk("stopplay.rd", mem_rd_en, 1'b0);
    chk("stopplay.pwm", pwm_out, 1'b0);
    chk("stopplay.pend", dut.pend_q, 4'h0);

    // cmd_play during PLAY restarts from the new range
    do_reset();
    start_play(4'd2, 4'd3, 1'b0, 3'd0);
    step(25);
    start_addr = 4'd5; end_addr = 4'd5;
    cmd_play = 1'b1;
    step(1);
    cmd_play = 1'b0;
    chk("restart.rd", mem_rd_en, 1'b1);
    chk("restart.addr", mem_addr, 4'd5);
    step(9);
    chk("restart.pend_old", dut.pend_q, 4'h3);
    step(1);
    chk("restart.pend_new", dut.pend_q, 4'hC);

    // reset mid-play with a read in flight
    do_reset();
    start_play(4'd2, 4'd3, 1'b0, 3'd0);
    step(20);
    rst = 1'b1;
    step(1);
    chk("midrst.rd", mem_rd_en, 1'b0);
    chk("midrst.addr", mem_addr, 4'd0);
    chk("midrst.pwm", pwm_out, 1'b0);
    chk("midrst.sd", aud_sd, 1'b0);
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.done", done, 1'b0);
    rst = 1'b0;
    step(12);
    chk("midrst.idle_busy", busy, 1'b0);
    chk("midrst.idle_pend", dut.pend_q, 4'h0);

    // looping never signals done
    do_reset();
    start_play(4'd2, 4'd3, 1'b1, 3'd0);
    cnt_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (done !== 1'b0) cnt_bad++;
      step(1);
    end
    chk("loop.no_done", cnt_bad, 0);
    chk("loop.busy", busy, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
